// File: rtl/otp_fsm.sv
// OTP array sequencer: programs one column row-by-row with pulse/verify/retry,
// or reads one column row-by-row into data_out.
module otp_fsm #(
    parameter int A            = 2,
    parameter int B            = 2,
    parameter int PULSE_CYCLES = 4,
    parameter int MAX_RETRY    = 3,
    localparam int ADDR_WIDTH  = $clog2(B)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] column,
    input  logic [A-1:0]          data_in,
    input  logic                  writing_successful,
    input  logic                  output_read_circuit,
    output logic [2*B-1:0]        PL,
    output logic [B-1:0]          BL,
    output logic [A-1:0]          WLN,
    output logic [A-1:0]          WLP,
    output logic                  read_active,
    output logic [A-1:0]          data_out,
    output logic [A-1:0]          fail_bits
);

    // state      | meaning
    // IDLE       | waiting for mode 1 (program) or 2 (read)
    // LATCH      | clear row/retry counters, branch on operation
    // PRG_SETUP  | select BL/WLP for row r, skipped when data bit r is 0
    // PRG_PULSE  | PL pair of the column high for PULSE_CYCLES clocks
    // PRG_VERIFY | PL low, check writing_successful, retry or flag fail
    // PRG_NEXT   | advance row or finish
    // RD_SETUP   | select BL/WLN for row r
    // RD_SAMPLE  | capture sense-amp output into data_out[r]
    // RD_NEXT    | advance row or finish
    // DONE       | lines low, wait for mode to return to idle
    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_LATCH      = 4'd1;
    localparam logic [3:0] S_PRG_SETUP  = 4'd2;
    localparam logic [3:0] S_PRG_PULSE  = 4'd3;
    localparam logic [3:0] S_PRG_VERIFY = 4'd4;
    localparam logic [3:0] S_PRG_NEXT   = 4'd5;
    localparam logic [3:0] S_RD_SETUP   = 4'd6;
    localparam logic [3:0] S_RD_SAMPLE  = 4'd7;
    localparam logic [3:0] S_RD_NEXT    = 4'd8;
    localparam logic [3:0] S_DONE       = 4'd9;

    localparam int RW  = (A > 1) ? $clog2(A) : 1;
    localparam int TW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int PW  = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int PLW = 2 * B;

    localparam logic [TW-1:0]  RETRY_LIMIT = TW'(MAX_RETRY);
    localparam logic [PW-1:0]  PULSE_LOAD  = PW'(PULSE_CYCLES - 1);
    localparam logic [RW-1:0]  LAST_ROW    = RW'(A - 1);
    localparam logic [PLW-1:0] PL_PAIR     = PLW'(3);

    logic [3:0]            state;
    logic                  op_read;
    logic [ADDR_WIDTH-1:0] col_q;
    logic [ADDR_WIDTH-1:0] col_clamped;
    logic [A-1:0]          data_q;
    logic [RW-1:0]         row_q;
    logic [TW-1:0]         retry_q;
    logic [PW-1:0]         pulse_q;
    logic                  mode_req;
    logic                  last_row;
    logic                  row_bit;
    logic [B-1:0]          col_hot;
    logic [A-1:0]          row_hot;

    // Mode 3 is reserved and behaves exactly like mode 0.
    assign mode_req    = (mode == 2'd1) || (mode == 2'd2);
    assign col_clamped = (32'(column) >= B) ? ADDR_WIDTH'(B - 1) : column;
    assign last_row    = (row_q == LAST_ROW);
    assign row_bit     = data_q[row_q];
    assign col_hot     = B'(1) << col_q;
    assign row_hot     = A'(1) << row_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            op_read   <= 1'b0;
            col_q     <= '0;
            data_q    <= '0;
            row_q     <= '0;
            retry_q   <= '0;
            pulse_q   <= '0;
            data_out  <= '0;
            fail_bits <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mode_req) begin
                        op_read <= (mode == 2'd2);
                        col_q   <= col_clamped;
                        data_q  <= data_in;
                        state   <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    row_q   <= '0;
                    retry_q <= '0;
                    if (op_read) begin
                        state <= S_RD_SETUP;
                    end else begin
                        fail_bits <= '0;
                        state     <= S_PRG_SETUP;
                    end
                end
                S_PRG_SETUP: begin
                    if (row_bit) begin
                        pulse_q <= PULSE_LOAD;
                        state   <= S_PRG_PULSE;
                    end else begin
                        state <= S_PRG_NEXT;
                    end
                end
                S_PRG_PULSE: begin
                    if (pulse_q == '0) begin
                        state <= S_PRG_VERIFY;
                    end else begin
                        pulse_q <= pulse_q - 1'b1;
                    end
                end
                S_PRG_VERIFY: begin
                    if (writing_successful) begin
                        state <= S_PRG_NEXT;
                    end else if (retry_q < RETRY_LIMIT) begin
                        retry_q <= retry_q + 1'b1;
                        pulse_q <= PULSE_LOAD;
                        state   <= S_PRG_PULSE;
                    end else begin
                        fail_bits[row_q] <= 1'b1;
                        state            <= S_PRG_NEXT;
                    end
                end
                S_PRG_NEXT: begin
                    retry_q <= '0;
                    if (last_row) begin
                        state <= S_DONE;
                    end else begin
                        row_q <= row_q + 1'b1;
                        state <= S_PRG_SETUP;
                    end
                end
                S_RD_SETUP: begin
                    state <= S_RD_SAMPLE;
                end
                S_RD_SAMPLE: begin
                    data_out[row_q] <= output_read_circuit;
                    state           <= S_RD_NEXT;
                end
                S_RD_NEXT: begin
                    if (last_row) begin
                        state <= S_DONE;
                    end else begin
                        row_q <= row_q + 1'b1;
                        state <= S_RD_SETUP;
                    end
                end
                S_DONE: begin
                    if (!mode_req) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Array lines are pure decodes of state so a reset edge drops them at once.
    always_comb begin
        PL          = '0;
        BL          = '0;
        WLN         = '0;
        WLP         = '0;
        read_active = 1'b0;
        case (state)
            S_PRG_SETUP: begin
                if (row_bit) begin
                    BL  = col_hot;
                    WLP = row_hot;
                end
            end
            S_PRG_PULSE: begin
                BL  = col_hot;
                WLP = row_hot;
                PL  = PL_PAIR << {col_q, 1'b0};
            end
            S_PRG_VERIFY: begin
                BL  = col_hot;
                WLP = row_hot;
            end
            S_RD_SETUP, S_RD_SAMPLE: begin
                BL          = col_hot;
                WLN         = row_hot;
                read_active = 1'b1;
            end
            S_RD_NEXT: begin
                read_active = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_otp_fsm.sv
// Directed bench for otp_fsm with default parameters (2 rows, 2 columns,
// 4-cycle pulse, 3 retries); per-cycle line activity is tallied per operation.
module tb_otp_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic [0:0] column;
    logic [1:0] data_in;
    logic       writing_successful;
    logic       output_read_circuit;
    logic [3:0] PL;
    logic [1:0] BL;
    logic [1:0] WLN;
    logic [1:0] WLP;
    logic       read_active;
    logic [1:0] data_out;
    logic [1:0] fail_bits;

    logic [1:0] rd_pattern;
    int         n_checks = 0;
    int         n_err    = 0;

    int         pl_cyc, pulses, wlp_cyc, wln_cyc, bl_cyc, ra_cyc, viol;
    logic [7:0] wln_hist;
    logic [3:0] exp_pl;
    logic [1:0] exp_bl;
    logic       pl_prev;
    logic [1:0] wln_prev;

    otp_fsm dut (
        .clk                 (clk),
        .reset               (reset),
        .mode                (mode),
        .column              (column),
        .data_in             (data_in),
        .writing_successful  (writing_successful),
        .output_read_circuit (output_read_circuit),
        .PL                  (PL),
        .BL                  (BL),
        .WLN                 (WLN),
        .WLP                 (WLP),
        .read_active         (read_active),
        .data_out            (data_out),
        .fail_bits           (fail_bits)
    );

    always #5 clk = ~clk;

    // Sense amp model: reports the stored bit of whichever row WLN selects.
    assign output_read_circuit = |(WLN & rd_pattern);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        pl_cyc   = 0;
        pulses   = 0;
        wlp_cyc  = 0;
        wln_cyc  = 0;
        bl_cyc   = 0;
        ra_cyc   = 0;
        viol     = 0;
        wln_hist = '0;
        pl_prev  = 1'b0;
        wln_prev = '0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (PL != 0) begin
                pl_cyc++;
                if (!pl_prev) pulses++;
                if (PL != exp_pl) viol++;
                if (read_active) viol++;
            end
            pl_prev = (PL != 0);
            if (BL != 0) begin
                bl_cyc++;
                if (BL != exp_bl) viol++;
            end
            if (WLP != 0) wlp_cyc++;
            if (WLN != 0) begin
                wln_cyc++;
                if (wln_prev == 0) wln_hist = {wln_hist[5:0], WLN};
            end
            wln_prev = WLN;
            if (read_active) ra_cyc++;
            if (WLN != 0 && WLP != 0) viol++;
            if (!$onehot0(BL) || !$onehot0(WLN) || !$onehot0(WLP)) viol++;
        end
    endtask

    task automatic start_op(input logic [1:0] m, input logic c, input logic [1:0] d,
                            input logic [3:0] epl, input logic [1:0] ebl);
        clear_stats();
        exp_pl  = epl;
        exp_bl  = ebl;
        column  = c;
        data_in = d;
        mode    = m;
    endtask

    task automatic back_to_idle();
        mode = 2'd0;
        run(2);
    endtask

    initial begin
        reset              = 1'b1;
        mode               = 2'd0;
        column             = 1'b0;
        data_in            = 2'b00;
        writing_successful = 1'b1;
        rd_pattern         = 2'b00;
        exp_pl             = '0;
        exp_bl             = '0;
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        check("reset_lines", {PL, BL, WLN, WLP, read_active}, 0);
        check("reset_data_out", data_out, 2'b00);
        check("reset_fail", fail_bits, 2'b00);
        reset = 1'b0;

        // Program with no bits set: no line ever moves, mode held at 1.
        start_op(2'd1, 1'b0, 2'b00, 4'b0000, 2'b01);
        run(20);
        check("zero_data_pl", pl_cyc, 0);
        check("zero_data_wlp", wlp_cyc, 0);
        check("zero_data_bl", bl_cyc, 0);
        back_to_idle();

        // Column 1, row 1 only, verify passes first time.
        start_op(2'd1, 1'b1, 2'b10, 4'b1100, 2'b10);
        run(25);
        check("prg_pl_cycles", pl_cyc, 4);
        check("prg_pulses", pulses, 1);
        check("prg_wlp_cycles", wlp_cyc, 6);
        check("prg_fail", fail_bits, 2'b00);
        check("prg_read_active", ra_cyc, 0);
        check("prg_violations", viol, 0);
        back_to_idle();

        // Same cell never verifies: first pulse plus three retries, then fail.
        writing_successful = 1'b0;
        start_op(2'd1, 1'b1, 2'b10, 4'b1100, 2'b10);
        run(40);
        check("retry_pl_cycles", pl_cyc, 16);
        check("retry_pulses", pulses, 4);
        check("retry_wlp_cycles", wlp_cyc, 21);
        check("retry_fail", fail_bits, 2'b10);
        check("retry_violations", viol, 0);
        back_to_idle();
        writing_successful = 1'b1;

        // Read column 0; mode switches to program mid-read and must be ignored.
        rd_pattern = 2'b01;
        start_op(2'd2, 1'b0, 2'b00, 4'b0000, 2'b01);
        run(3);
        mode = 2'd1;
        run(15);
        check("rd0_data_out", data_out, 2'b01);
        check("rd0_read_active", ra_cyc, 6);
        check("rd0_wln_cycles", wln_cyc, 4);
        check("rd0_wln_order", wln_hist, 8'h06);
        check("rd0_bl_cycles", bl_cyc, 4);
        check("rd0_no_program", pl_cyc + wlp_cyc, 0);
        check("rd0_violations", viol, 0);
        back_to_idle();

        rd_pattern = 2'b10;
        start_op(2'd2, 1'b1, 2'b00, 4'b0000, 2'b10);
        run(15);
        check("rd1_data_out", data_out, 2'b10);
        check("rd1_read_active", ra_cyc, 6);
        check("rd1_violations", viol, 0);
        back_to_idle();

        // Programming both rows must leave data_out untouched.
        start_op(2'd1, 1'b0, 2'b11, 4'b0011, 2'b01);
        run(30);
        check("prg2_pl_cycles", pl_cyc, 8);
        check("prg2_pulses", pulses, 2);
        check("prg2_data_out_kept", data_out, 2'b10);
        check("prg2_violations", viol, 0);
        back_to_idle();

        // Reset in the first pulse cycle drops every line on the next edge.
        start_op(2'd1, 1'b1, 2'b11, 4'b1100, 2'b10);
        for (int i = 0; i < 20 && PL == 0; i++) run(1);
        check("abort_pulse_seen", PL, 4'b1100);
        reset = 1'b1;
        mode  = 2'd0;
        @(posedge clk);
        #1;
        check("abort_lines", {PL, BL, WLP, WLN, read_active}, 0);
        check("abort_data_out", data_out, 2'b00);
        reset = 1'b0;

        // Reserved mode stays idle.
        start_op(2'd3, 1'b0, 2'b11, 4'b0011, 2'b01);
        run(10);
        check("mode3_idle", pl_cyc + wlp_cyc + wln_cyc + bl_cyc + ra_cyc, 0);

        // Program, drop to idle, then read: two complete operations.
        start_op(2'd1, 1'b1, 2'b01, 4'b1100, 2'b10);
        run(20);
        check("seq_prg_pl_cycles", pl_cyc, 4);
        check("seq_prg_violations", viol, 0);
        back_to_idle();
        rd_pattern = 2'b11;
        start_op(2'd2, 1'b1, 2'b00, 4'b0000, 2'b10);
        run(15);
        check("seq_rd_data_out", data_out, 2'b11);
        check("seq_rd_read_active", ra_cyc, 6);
        check("seq_rd_violations", viol, 0);
        back_to_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
